tl_conflict_monitor: RTL and testbench

Independent safety monitor for the T-intersection signal controller. It observes the four 3-bit lamp buses the controller drives and checks every sampled value for illegal codes, conflicting greens, illegal colour sequences, short phases and a stalled controller. On the first violation it latches a sticky fault with a cause code and a lamp index. Board logic uses the fault to force flashing-red and to raise an alarm LED.

---
 rtl/tl_pkg.sv | 47 ++++
 rtl/tl_lamp_checker.sv | 57 +++++
 rtl/tl_conflict_monitor.sv | 148 ++++++++++++++
 tb/tb_tl_conflict_monitor.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/tl_pkg.sv
// Shared definitions for the T-intersection signal controller and its safety monitor.
package tl_pkg;

   localparam logic [2:0] LAMP_DARK   = 3'b000;
   localparam logic [2:0] LAMP_GREEN  = 3'b001;
   localparam logic [2:0] LAMP_YELLOW = 3'b010;
   localparam logic [2:0] LAMP_RED    = 3'b100;

   localparam logic [2:0] FLT_NONE     = 3'd0;
   localparam logic [2:0] FLT_ILLEGAL  = 3'd1;
   localparam logic [2:0] FLT_CONFLICT = 3'd2;
   localparam logic [2:0] FLT_BAD_SEQ  = 3'd3;
   localparam logic [2:0] FLT_SHORT    = 3'd4;
   localparam logic [2:0] FLT_STUCK    = 3'd5;

   localparam logic [1:0] LAMP_M1 = 2'd0;
   localparam logic [1:0] LAMP_MT = 2'd1;
   localparam logic [1:0] LAMP_M2 = 2'd2;
   localparam logic [1:0] LAMP_S  = 2'd3;

   // Bit 0 is the armed flag and bit 1 the fault flag, so both outputs come straight off the state register.
   typedef enum logic [1:0] {
      ST_DISARMED = 2'b00,
      ST_ARMED    = 2'b01,
      ST_FAULT    = 2'b10
   } mon_state_e;

   function automatic logic lamp_legal(input logic [2:0] v);
      return (v == LAMP_GREEN) || (v == LAMP_YELLOW) || (v == LAMP_RED);
   endfunction

   function automatic logic seq_ok(input logic [2:0] p, input logic [2:0] c);
      return ((p == LAMP_GREEN)  && (c == LAMP_YELLOW)) ||
             ((p == LAMP_YELLOW) && (c == LAMP_RED))    ||
             ((p == LAMP_RED)    && (c == LAMP_GREEN));
   endfunction

   function automatic logic [1:0] lowest_idx(input logic [3:0] v);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (v[i]) idx = 2'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/tl_lamp_checker.sv
// Per-lamp checker: previous value, dwell counter and first-phase flag, with
// illegal-code, bad-sequence and short-phase flags for the current sample.
module tl_lamp_checker
   import tl_pkg::*;
#(
   parameter int         CNT_W      = 40,
   parameter logic [63:0] MIN_GREEN  = 64'd2_000_000_000,
   parameter logic [63:0] MIN_YELLOW = 64'd400_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic       active,
   input  logic [2:0] led,
   output logic       changed,
   output logic       illegal,
   output logic       bad_seq,
   output logic       short_phase
);

   logic [2:0]       prev_q, prev_d;
   logic [CNT_W-1:0] dwell_q, dwell_d;
   logic             first_q, first_d;

   always_comb begin
      changed     = (led != prev_q);
      illegal     = !lamp_legal(led);
      bad_seq     = changed && !seq_ok(prev_q, led);
      // The dwell compared here is the pre-reset value; the partial phase seen at arming is exempt.
      short_phase = changed && !first_q &&
                    (((prev_q == LAMP_GREEN)  && (64'(dwell_q) < MIN_GREEN)) ||
                     ((prev_q == LAMP_YELLOW) && (64'(dwell_q) < MIN_YELLOW)));

      prev_d = led;

      if (load || changed) dwell_d = CNT_W'(1);
      else if (&dwell_q)   dwell_d = dwell_q;
      else                 dwell_d = dwell_q + CNT_W'(1);

      first_d = first_q;
      if (load)                  first_d = 1'b1;
      else if (active && changed) first_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q  <= LAMP_DARK;
         dwell_q <= '0;
         first_q <= 1'b0;
      end else begin
         prev_q  <= prev_d;
         dwell_q <= dwell_d;
         first_q <= first_d;
      end
   end

endmodule

// File: rtl/tl_conflict_monitor.sv
// Independent safety monitor for the T-intersection lamps: arms on a legal
// pattern, then latches the first violation as a sticky fault with cause and lamp.
module tl_conflict_monitor
   import tl_pkg::*;
#(
   parameter int          CNT_W      = 40,
   parameter logic [63:0] MIN_GREEN  = 64'd2_000_000_000,
   parameter logic [63:0] MIN_YELLOW = 64'd400_000_000,
   parameter logic [63:0] WDOG_MAX   = 64'd4_000_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] led_M1,
   input  logic [2:0] led_MT,
   input  logic [2:0] led_M2,
   input  logic [2:0] led_S,
   input  logic       clr_fault,
   output logic       armed,
   output logic       fault,
   output logic [2:0] fault_code,
   output logic [1:0] fault_lamp
);

   logic [2:0] led_a [4];
   logic [3:0] changed, illegal, bad_seq, short_v, non_red;
   logic       arm_load, armed_now;
   logic       conf_mt_m2, conf_s;
   logic       stuck;
   logic [2:0] viol_code;
   logic [1:0] viol_lamp;

   mon_state_e       state_q, state_d;
   logic [2:0]       fault_code_q, fault_code_d;
   logic [1:0]       fault_lamp_q, fault_lamp_d;
   logic [CNT_W-1:0] wdog_q, wdog_d, wdog_inc;

   assign led_a[LAMP_M1] = led_M1;
   assign led_a[LAMP_MT] = led_MT;
   assign led_a[LAMP_M2] = led_M2;
   assign led_a[LAMP_S]  = led_S;

   assign armed_now = (state_q == ST_ARMED);

   for (genvar i = 0; i < 4; i++) begin : g_chk
      tl_lamp_checker #(
         .CNT_W      (CNT_W),
         .MIN_GREEN  (MIN_GREEN),
         .MIN_YELLOW (MIN_YELLOW)
      ) u_chk (
         .clk         (clk),
         .rst_n       (rst_n),
         .load        (arm_load),
         .active      (armed_now),
         .led         (led_a[i]),
         .changed     (changed[i]),
         .illegal     (illegal[i]),
         .bad_seq     (bad_seq[i]),
         .short_phase (short_v[i])
      );
      assign non_red[i] = (led_a[i] != LAMP_RED);
   end

   // MT/M2 reports lamp M2; any S pairing reports lamp S, which loses to M2 on a tie.
   assign conf_mt_m2 = non_red[LAMP_MT] && non_red[LAMP_M2];
   assign conf_s     = non_red[LAMP_S] && (non_red[LAMP_M1] || non_red[LAMP_MT] || non_red[LAMP_M2]);

   assign wdog_inc = (&wdog_q) ? wdog_q : wdog_q + CNT_W'(1);
   assign stuck    = !(|changed) && (64'(wdog_inc) >= WDOG_MAX);

   always_comb begin
      viol_code = FLT_NONE;
      viol_lamp = LAMP_M1;
      if (|illegal) begin
         viol_code = FLT_ILLEGAL;
         viol_lamp = lowest_idx(illegal);
      end else if (conf_mt_m2 || conf_s) begin
         viol_code = FLT_CONFLICT;
         viol_lamp = conf_mt_m2 ? LAMP_M2 : LAMP_S;
      end else if (|bad_seq) begin
         viol_code = FLT_BAD_SEQ;
         viol_lamp = lowest_idx(bad_seq);
      end else if (|short_v) begin
         viol_code = FLT_SHORT;
         viol_lamp = lowest_idx(short_v);
      end else if (stuck) begin
         viol_code = FLT_STUCK;
      end
   end

   always_comb begin
      state_d      = state_q;
      fault_code_d = fault_code_q;
      fault_lamp_d = fault_lamp_q;
      wdog_d       = '0;
      arm_load     = 1'b0;
      case (state_q)
         ST_DISARMED: begin
            if (!clr_fault && !(|illegal)) begin
               state_d  = ST_ARMED;
               arm_load = 1'b1;
            end
         end
         ST_ARMED: begin
            if (clr_fault) begin
               state_d = ST_DISARMED;
            end else if (viol_code != FLT_NONE) begin
               state_d      = ST_FAULT;
               fault_code_d = viol_code;
               fault_lamp_d = viol_lamp;
            end else begin
               wdog_d = (|changed) ? '0 : wdog_inc;
            end
         end
         ST_FAULT: begin
            if (clr_fault) begin
               state_d      = ST_DISARMED;
               fault_code_d = FLT_NONE;
               fault_lamp_d = LAMP_M1;
            end
         end
         default: begin
            state_d      = ST_DISARMED;
            fault_code_d = FLT_NONE;
            fault_lamp_d = LAMP_M1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_DISARMED;
         fault_code_q <= FLT_NONE;
         fault_lamp_q <= LAMP_M1;
         wdog_q       <= '0;
      end else begin
         state_q      <= state_d;
         fault_code_q <= fault_code_d;
         fault_lamp_q <= fault_lamp_d;
         wdog_q       <= wdog_d;
      end
   end

   assign armed      = state_q[0];
   assign fault      = state_q[1];
   assign fault_code = fault_code_q;
   assign fault_lamp = fault_lamp_q;

endmodule

// File: tb/tb_tl_conflict_monitor.sv
// Directed bench for tl_conflict_monitor: each step drives the lamps, queues the
// expected {armed, fault, fault_code, fault_lamp} and checks it after the edge.
module tb_tl_conflict_monitor;

   localparam logic [2:0] G = 3'b001;
   localparam logic [2:0] Y = 3'b010;
   localparam logic [2:0] R = 3'b100;
   localparam logic [2:0] D = 3'b000;

   localparam logic [6:0] EXP_IDLE = 7'b0000000;
   localparam logic [6:0] EXP_ARM  = 7'b1000000;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] led_M1 = D, led_MT = D, led_M2 = D, led_S = D;
   logic       clr_fault = 1'b0;
   logic       armed, fault;
   logic [2:0] fault_code;
   logic [1:0] fault_lamp;

   logic [6:0] exp_q[$];
   int         vectors = 0;
   int         miscompares = 0;

   tl_conflict_monitor #(
      .CNT_W      (8),
      .MIN_GREEN  (8),
      .MIN_YELLOW (3),
      .WDOG_MAX   (40)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .led_M1     (led_M1),
      .led_MT     (led_MT),
      .led_M2     (led_M2),
      .led_S      (led_S),
      .clr_fault  (clr_fault),
      .armed      (armed),
      .fault      (fault),
      .fault_code (fault_code),
      .fault_lamp (fault_lamp)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] fexp(input logic [2:0] code, input logic [1:0] lamp);
      return {2'b01, code, lamp};
   endfunction

   task automatic compare_now(input logic [6:0] e, input string tag);
      logic [6:0] obs;
      obs = {armed, fault, fault_code, fault_lamp};
      vectors++;
      assert (obs === e) else begin
         miscompares++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, e);
      end
   endtask

   task automatic step(input logic [2:0] m1, input logic [2:0] mt, input logic [2:0] m2,
                       input logic [2:0] s, input logic clr, input logic [6:0] e, input string tag);
      @(negedge clk);
      led_M1 = m1; led_MT = mt; led_M2 = m2; led_S = s; clr_fault = clr;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      compare_now(exp_q.pop_front(), tag);
   endtask

   task automatic hold(input int n, input logic [2:0] m1, input logic [2:0] mt, input logic [2:0] m2,
                       input logic [2:0] s, input logic [6:0] e, input string tag);
      for (int i = 0; i < n; i++) step(m1, mt, m2, s, 1'b0, e, tag);
   endtask

   task automatic round(input string tag);
      hold(10, G, G, R, R, EXP_ARM, tag);
      hold(4,  Y, Y, R, R, EXP_ARM, tag);
      hold(10, R, R, G, R, EXP_ARM, tag);
      hold(4,  R, R, Y, R, EXP_ARM, tag);
      hold(10, R, R, R, G, EXP_ARM, tag);
      hold(4,  R, R, R, Y, EXP_ARM, tag);
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      rst_n = 1'b0;
      led_M1 = D; led_MT = D; led_M2 = D; led_S = D; clr_fault = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      compare_now(EXP_IDLE, tag);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      // Normal operation: dark and partly dark patterns never arm.
      do_reset("reset_state");
      hold(2, D, D, D, D, EXP_IDLE, "dark_disarmed");
      step(G, G, R, D, 1'b0, EXP_IDLE, "partial_dark_disarmed");
      round("normal_r1");
      round("normal_r2");
      round("normal_r3");

      // Conflict S with MT on the same edge.
      do_reset("reset_conflict");
      hold(3, R, R, R, R, EXP_ARM, "all_red_arm");
      step(R, G, R, G, 1'b0, fexp(3'd2, 2'd3), "conflict_s_mt");
      step(R, R, R, R, 1'b0, fexp(3'd2, 2'd3), "conflict_sticky");

      // Green straight to red on M2, then an illegal code that must not overwrite.
      do_reset("reset_badseq");
      round("badseq_r1");
      hold(10, G, G, R, R, EXP_ARM, "badseq_p1");
      hold(4,  Y, Y, R, R, EXP_ARM, "badseq_p2");
      hold(10, R, R, G, R, EXP_ARM, "badseq_p3");
      step(R, R, R, R, 1'b0, fexp(3'd3, 2'd2), "badseq_m2");
      step(R, 3'b011, R, R, 1'b0, fexp(3'd3, 2'd2), "badseq_sticky");

      // Short yellow exempt in the first phase after arming.
      do_reset("reset_first_phase");
      hold(2, Y, R, R, R, EXP_ARM, "first_phase_yellow");
      hold(2, R, R, R, R, EXP_ARM, "first_phase_exempt");

      // Short yellow on M1 after a full round.
      do_reset("reset_short");
      round("short_r1");
      hold(10, G, G, R, R, EXP_ARM, "short_p1");
      hold(2,  Y, G, R, R, EXP_ARM, "short_yellow");
      step(R, G, R, R, 1'b0, fexp(3'd4, 2'd0), "short_m1");

      // Watchdog: arming edge, then 40 edges with no change.
      do_reset("reset_stuck");
      step(R, R, R, R, 1'b0, EXP_ARM, "stuck_arm");
      hold(39, R, R, R, R, EXP_ARM, "stuck_wait");
      step(R, R, R, R, 1'b0, fexp(3'd5, 2'd0), "stuck_fault");
      step(R, R, R, R, 1'b1, EXP_IDLE, "clear_fault");
      step(R, R, R, R, 1'b0, EXP_ARM, "rearm");
      step(R, G, R, G, 1'b1, EXP_IDLE, "clear_beats_conflict");
      step(R, R, R, R, 1'b0, EXP_ARM, "rearm_again");
      hold(2, R, R, R, R, EXP_ARM, "rearm_hold");

      // Dark lamp once armed, then asynchronous reset between edges.
      do_reset("reset_dark");
      step(R, R, R, R, 1'b0, EXP_ARM, "dark_arm");
      step(R, R, R, D, 1'b0, fexp(3'd1, 2'd3), "dark_s_illegal");
      #2;
      rst_n = 1'b0;
      #1;
      compare_now(EXP_IDLE, "async_reset");
      #3;
      rst_n = 1'b1;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
